// File: rtl/psum_postproc_pkg.sv
// psum_postproc_pkg: shared BRAM/psum parameters, FSM states and lane-mask helper
package psum_postproc_pkg;
  localparam int BRAM_WIDTH = 32;
  localparam int BRAM_ADDR_BIT = 32;
  localparam int BRAM_BYTE = BRAM_WIDTH / 8;
  localparam int PSUM_WIDTH = 8;
  localparam int NO_ENTRY_BIT = 16;
  localparam int LANE_BIT = $clog2(BRAM_BYTE);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  function automatic logic [BRAM_BYTE-1:0] keep_mask(input logic [LANE_BIT-1:0] rem);
    logic [BRAM_BYTE-1:0] m;
    m = '1;
    return rem == '0 ? m : ~(m << rem);
  endfunction
endpackage

// File: rtl/pp_out_fifo.sv
// pp_out_fifo: show-ahead synchronous FIFO with occupancy count
module pp_out_fifo #(
  parameter int W = 37,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign valid = cnt != '0;
  assign do_push = push && cnt != (AW+1)'(DEPTH);
  assign do_pop = pop && valid;
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/psum_postproc.sv
// psum_postproc: drains packed psums from the accumulation BRAM, optional ReLU and clear, to a stream
module psum_postproc
  import psum_postproc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [BRAM_ADDR_BIT-1:0] base_addr,
  input  logic [NO_ENTRY_BIT-1:0]  no_entry,
  input  logic                     relu_en,
  input  logic                     clear_en,
  output logic                     busy,
  output logic                     done,
  output logic                     BRAM_clk,
  output logic                     BRAM_en,
  output logic                     BRAM_rst,
  output logic [BRAM_ADDR_BIT-1:0] BRAM_addr,
  output logic [BRAM_BYTE-1:0]     BRAM_wen,
  output logic [BRAM_WIDTH-1:0]    BRAM_din,
  input  logic [BRAM_WIDTH-1:0]    BRAM_dout,
  output logic [BRAM_WIDTH-1:0]    m_tdata,
  output logic [BRAM_BYTE-1:0]     m_tkeep,
  output logic                     m_tlast,
  output logic                     m_tvalid,
  input  logic                     m_tready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = BRAM_WIDTH + BRAM_BYTE + 1;
  localparam int WB = NO_ENTRY_BIT - LANE_BIT + 1;
  state_t st, st_nx;
  logic [BRAM_ADDR_BIT-1:0] addr, a_w;
  logic [WB-1:0] left, words;
  logic [LANE_BIT-1:0] rem, r_w;
  logic relu, clr, none, go, issue, xfer, last_w, f_valid;
  logic iss_last, rd_v, rd_last;
  logic [BRAM_BYTE-1:0] iss_keep, rd_keep, keep_w;
  logic [CW-1:0] cnt;
  logic [CW+1:0] pend;
  logic [BRAM_WIDTH-1:0] lanes;
  logic [FW-1:0] f_dout;
  assign BRAM_clk = clk;
  assign BRAM_rst = 1'b0;
  assign BRAM_din = '0;
  assign busy = st == RUN || st == DRAIN;
  assign done = st == DONE;
  assign words = WB'(no_entry[NO_ENTRY_BIT-1:LANE_BIT]) + WB'(|no_entry[LANE_BIT-1:0]);
  assign go = st == IDLE && start;
  // Credit covers reads on the port, data on dout and words already buffered
  assign pend = (CW+2)'(cnt) + (CW+2)'(BRAM_en) + (CW+2)'(rd_v);
  assign issue = go ? words != '0 : st == RUN && pend < (CW+2)'(FIFO_DEPTH);
  assign a_w = go ? base_addr & ~BRAM_ADDR_BIT'(BRAM_BYTE - 1) : addr;
  assign r_w = go ? no_entry[LANE_BIT-1:0] : rem;
  assign last_w = go ? words == WB'(1) : left == WB'(1);
  assign keep_w = last_w ? keep_mask(r_w) : '1;
  assign xfer = m_tvalid && m_tready;
  always_comb begin
    st_nx = st;
    st_nx = st == IDLE  ? (start ? (words > WB'(1) ? RUN : DRAIN) : IDLE)
          : st == RUN   ? (issue && left == WB'(1) ? DRAIN : RUN)
          : st == DRAIN ? ((xfer && m_tlast) || none ? DONE : DRAIN)
          : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      addr <= '0;
      left <= '0;
      rem <= '0;
      relu <= 1'b0;
      clr <= 1'b0;
      none <= 1'b0;
      BRAM_en <= 1'b0;
      BRAM_addr <= '0;
      BRAM_wen <= '0;
      iss_keep <= '0;
      iss_last <= 1'b0;
      rd_v <= 1'b0;
      rd_keep <= '0;
      rd_last <= 1'b0;
    end else begin
      st <= st_nx;
      if (go) begin
        rem <= no_entry[LANE_BIT-1:0];
        relu <= relu_en;
        clr <= clear_en;
        none <= words == '0;
      end
      if (issue) begin
        addr <= a_w + BRAM_ADDR_BIT'(BRAM_BYTE);
        left <= (go ? words : left) - WB'(1);
        BRAM_addr <= a_w;
      end
      BRAM_en <= issue;
      BRAM_wen <= issue && (go ? clear_en : clr) ? keep_w : '0;
      iss_keep <= keep_w;
      iss_last <= last_w;
      rd_v <= BRAM_en;
      rd_keep <= iss_keep;
      rd_last <= iss_last;
    end
  end
  // Lanes past no_entry and negative lanes under ReLU become zero
  always_comb begin
    lanes = '0;
    for (int i = 0; i < BRAM_BYTE; i++)
      lanes[i*PSUM_WIDTH +: PSUM_WIDTH] = rd_keep[i] && !(relu && BRAM_dout[i*PSUM_WIDTH+PSUM_WIDTH-1])
                                        ? BRAM_dout[i*PSUM_WIDTH +: PSUM_WIDTH] : '0;
  end
  pp_out_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(rd_v),
    .din({rd_last, rd_keep, lanes}),
    .pop(xfer),
    .dout(f_dout),
    .valid(f_valid),
    .cnt(cnt)
  );
  assign m_tvalid = f_valid;
  assign {m_tlast, m_tkeep, m_tdata} = f_valid ? f_dout : '0;
endmodule

// File: tb/tb_psum_postproc.sv
// tb_psum_postproc: scoreboard bench for psum_postproc with a READ_FIRST BRAM model
module tb_psum_postproc;
  import psum_postproc_pkg::*;
  typedef struct packed {logic [31:0] d; logic [3:0] k; logic l;} exp_t;
  logic clk, rst, start, relu_en, clear_en, busy, done;
  logic [31:0] base_addr;
  logic [15:0] no_entry;
  logic BRAM_clk, BRAM_en, BRAM_rst;
  logic [31:0] BRAM_addr, BRAM_din, BRAM_dout, m_tdata;
  logic [3:0] BRAM_wen, m_tkeep;
  logic m_tlast, m_tvalid, m_tready;
  logic [31:0] mem [0:1023];
  exp_t q[$];
  int compared = 0, mismatched = 0, outst = 0, maxo = 0;
  logic pv = 0, pr = 0;
  logic [36:0] pd;
  psum_postproc #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .no_entry(no_entry),
    .relu_en(relu_en), .clear_en(clear_en), .busy(busy), .done(done),
    .BRAM_clk(BRAM_clk), .BRAM_en(BRAM_en), .BRAM_rst(BRAM_rst), .BRAM_addr(BRAM_addr),
    .BRAM_wen(BRAM_wen), .BRAM_din(BRAM_din), .BRAM_dout(BRAM_dout),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready)
  );
  always #5 clk = ~clk;
  always @(posedge BRAM_clk)
    if (BRAM_en) begin
      BRAM_dout <= mem[BRAM_addr[11:2]];
      for (int b = 0; b < 4; b++)
        if (BRAM_wen[b]) mem[BRAM_addr[11:2]][b*8 +: 8] <= BRAM_din[b*8 +: 8];
    end
  function automatic exp_t model(input logic [31:0] w, input logic [3:0] k, input logic relu, input logic last);
    exp_t r;
    logic [7:0] v;
    r.k = k;
    r.l = last;
    for (int b = 0; b < 4; b++) begin
      v = w[b*8 +: 8];
      r.d[b*8 +: 8] = (k[b] && !(relu && v[7])) ? v : 8'h00;
    end
    return r;
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      outst = 0;
      pv = 0;
      pr = 0;
    end else begin
      if (pv && !pr) begin
        compared++;
        if (!m_tvalid || {m_tdata, m_tkeep, m_tlast} !== pd) begin
          mismatched++;
          $display("FAIL stall_hold: got valid=%0b %h want valid=1 %h", m_tvalid, {m_tdata, m_tkeep, m_tlast}, pd);
        end
      end
      if (BRAM_en) outst++;
      if (m_tvalid && m_tready) begin
        outst--;
        compared++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL stream_extra: got %h want nothing", {m_tdata, m_tkeep, m_tlast});
        end else begin
          exp_t e;
          e = q.pop_front();
          if ({m_tdata, m_tkeep, m_tlast} !== e) begin
            mismatched++;
            $display("FAIL stream_word: got d=%h k=%h l=%0b want d=%h k=%h l=%0b", m_tdata, m_tkeep, m_tlast, e.d, e.k, e.l);
          end
        end
      end
      if (outst > maxo) maxo = outst;
      pv = m_tvalid;
      pr = m_tready;
      pd = {m_tdata, m_tkeep, m_tlast};
    end
  end
  // Queues the expected stream from the memory model, then pulses start; returns in cycle T+1
  task automatic start_drain(input logic [31:0] base, input logic [15:0] n, input logic relu, input logic clr);
    int nw, rem;
    logic [3:0] f, k;
    nw = (int'(n) + 3) / 4;
    rem = int'(n) % 4;
    f = 4'hF;
    for (int i = 0; i < nw; i++) begin
      k = (i == nw - 1 && rem != 0) ? f >> (4 - rem) : f;
      q.push_back(model(mem[10'(int'(base[11:2]) + i)], k, relu, i == nw - 1));
    end
    @(posedge clk) #1;
    start = 1;
    base_addr = base;
    no_entry = n;
    relu_en = relu;
    clear_en = clr;
    @(posedge clk) #1;
    start = 0;
  endtask
  task automatic test_reset;
    logic [109:0] obs;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    obs = {busy, done, m_tvalid, m_tlast, m_tkeep, m_tdata, BRAM_en, BRAM_wen, BRAM_addr, BRAM_din, BRAM_rst};
    compared++;
    if (obs !== '0) begin mismatched++; $display("FAIL reset_outputs: got %h want 0", obs); end
    @(posedge clk) #1;
    rst = 0;
  endtask
  task automatic test_relu;
    mem[10'h40] = 32'h7F80_0102;
    mem[10'h41] = 32'hFF00_1020;
    start_drain(32'h100, 16'd8, 1'b1, 1'b0);
    @(negedge clk);
    compared++;
    if ({BRAM_en, BRAM_addr, BRAM_wen} !== {1'b1, 32'h100, 4'h0}) begin mismatched++; $display("FAIL relu_issue0: got en=%0b a=%h w=%h want 1 100 0", BRAM_en, BRAM_addr, BRAM_wen); end
    @(negedge clk);
    compared++;
    if ({BRAM_en, BRAM_addr, m_tvalid} !== {1'b1, 32'h104, 1'b0}) begin mismatched++; $display("FAIL relu_issue1: got en=%0b a=%h v=%0b want 1 104 0", BRAM_en, BRAM_addr, m_tvalid); end
    @(negedge clk);
    compared++;
    if ({m_tvalid, m_tdata, m_tkeep, m_tlast} !== {1'b1, 32'h7F00_0102, 4'hF, 1'b0}) begin mismatched++; $display("FAIL relu_word0_t3: got v=%0b %h %h %0b want 1 7f000102 f 0", m_tvalid, m_tdata, m_tkeep, m_tlast); end
    @(negedge clk);
    compared++;
    if ({m_tvalid, m_tdata, m_tkeep, m_tlast, done} !== {1'b1, 32'h0000_1020, 4'hF, 1'b1, 1'b0}) begin mismatched++; $display("FAIL relu_word1_t4: got v=%0b %h %h %0b done=%0b want 1 00001020 f 1 0", m_tvalid, m_tdata, m_tkeep, m_tlast, done); end
    @(negedge clk);
    compared++;
    if ({done, busy, m_tvalid} !== 3'b100) begin mismatched++; $display("FAIL relu_done_t5: got done=%0b busy=%0b v=%0b want 1 0 0", done, busy, m_tvalid); end
    @(negedge clk);
    compared++;
    if ({done, mem[10'h40], mem[10'h41]} !== {1'b0, 32'h7F80_0102, 32'hFF00_1020}) begin mismatched++; $display("FAIL relu_bram_kept: got done=%0b %h %h want 0 7f800102 ff001020", done, mem[10'h40], mem[10'h41]); end
    compared++;
    if (q.size() != 0) begin mismatched++; $display("FAIL relu_queue: got %0d left want 0", q.size()); end
  endtask
  task automatic test_clear;
    logic got;
    mem[10'h80] = 32'h8899_AABB;
    mem[10'h81] = 32'hAABB_CCDD;
    start_drain(32'h200, 16'd6, 1'b0, 1'b1);
    @(negedge clk);
    compared++;
    if (BRAM_wen !== 4'hF) begin mismatched++; $display("FAIL clear_wen0: got %h want f", BRAM_wen); end
    @(negedge clk);
    compared++;
    if (BRAM_wen !== 4'h3) begin mismatched++; $display("FAIL clear_wen1: got %h want 3", BRAM_wen); end
    @(negedge clk);
    compared++;
    if ({BRAM_en, BRAM_wen} !== 5'h0) begin mismatched++; $display("FAIL clear_idle_port: got en=%0b w=%h want 0 0", BRAM_en, BRAM_wen); end
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin @(negedge clk); got = done; end
    compared++;
    if (!got) begin mismatched++; $display("FAIL clear_done: got timeout want done"); end
    compared++;
    if ({mem[10'h80], mem[10'h81]} !== {32'h0, 32'hAABB_0000}) begin mismatched++; $display("FAIL clear_bram: got %h %h want 00000000 aabb0000", mem[10'h80], mem[10'h81]); end
    compared++;
    if (q.size() != 0) begin mismatched++; $display("FAIL clear_queue: got %0d left want 0", q.size()); end
  endtask
  task automatic test_back_to_back_stall;
    logic got;
    for (int i = 0; i < 4; i++) mem[10'hC0 + 10'(i)] = $urandom;
    mem[10'hC1][31:24] = 8'h80;
    maxo = 0;
    start_drain(32'h300, 16'd16, 1'b1, 1'b0);
    got = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      m_tready = (c % 3) == 0;
      @(negedge clk);
      got = done;
      @(posedge clk) #1;
    end
    m_tready = 1;
    compared++;
    if (!got) begin mismatched++; $display("FAIL stall_done: got timeout want done"); end
    compared++;
    if (q.size() != 0) begin mismatched++; $display("FAIL stall_queue: got %0d left want 0", q.size()); end
    compared++;
    if (maxo > 4) begin mismatched++; $display("FAIL stall_occupancy: got %0d want <=4", maxo); end
  endtask
  task automatic test_zero;
    int en_n = 0, v_n = 0, done_k = 0;
    start_drain(32'h100, 16'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (BRAM_en || BRAM_wen != 0) en_n++;
      if (m_tvalid) v_n++;
      if (done && done_k == 0) done_k = k;
    end
    compared++;
    if (done_k != 2) begin mismatched++; $display("FAIL zero_done_cycle: got %0d want 2", done_k); end
    compared++;
    if (en_n != 0 || v_n != 0) begin mismatched++; $display("FAIL zero_activity: got bram=%0d valid=%0d want 0 0", en_n, v_n); end
  endtask
  task automatic test_reset_mid;
    int seen = 0;
    logic got;
    logic [109:0] obs;
    for (int i = 0; i < 8; i++) mem[10'h100 + 10'(i)] = $urandom;
    start_drain(32'h400, 16'd32, 1'b0, 1'b0);
    for (int i = 0; i < 40 && seen < 2; i++) begin
      @(negedge clk);
      if (m_tvalid && m_tready) seen++;
    end
    compared++;
    if (seen != 2) begin mismatched++; $display("FAIL rstmid_progress: got %0d transfers want 2", seen); end
    @(posedge clk) #1;
    rst = 1;
    @(posedge clk) #1;
    rst = 0;
    q.delete();
    @(negedge clk);
    obs = {busy, done, m_tvalid, m_tlast, m_tkeep, m_tdata, BRAM_en, BRAM_wen, BRAM_addr, BRAM_din, BRAM_rst};
    compared++;
    if (obs !== '0) begin mismatched++; $display("FAIL rstmid_outputs: got %h want 0", obs); end
    mem[10'h100] = 32'h80FF_7F01;
    start_drain(32'h400, 16'd4, 1'b1, 1'b0);
    @(negedge clk);
    compared++;
    if ({BRAM_en, BRAM_addr} !== {1'b1, 32'h400}) begin mismatched++; $display("FAIL rstmid_restart_addr: got en=%0b a=%h want 1 400", BRAM_en, BRAM_addr); end
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin @(negedge clk); got = done; end
    compared++;
    if (!got || q.size() != 0) begin mismatched++; $display("FAIL rstmid_restart: got done=%0b left=%0d want 1 0", got, q.size()); end
  endtask
  task automatic test_start_busy;
    logic got;
    int act = 0;
    for (int i = 0; i < 2; i++) mem[10'h140 + 10'(i)] = $urandom;
    start_drain(32'h500, 16'd8, 1'b0, 1'b0);
    start = 1;
    base_addr = 32'h600;
    no_entry = 16'd4;
    relu_en = 1;
    clear_en = 1;
    @(posedge clk) #1;
    start = 0;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin @(negedge clk); got = done; end
    start = 1;
    @(posedge clk) #1;
    start = 0;
    compared++;
    if (!got) begin mismatched++; $display("FAIL busy_done: got timeout want done"); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (BRAM_en || m_tvalid || busy) act++;
    end
    compared++;
    if (act != 0 || q.size() != 0) begin mismatched++; $display("FAIL busy_ignored: got activity=%0d left=%0d want 0 0", act, q.size()); end
  endtask
  initial begin
    clk = 0;
    rst = 1;
    start = 0;
    base_addr = 0;
    no_entry = 0;
    relu_en = 0;
    clear_en = 0;
    m_tready = 1;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    test_reset;
    test_relu;
    test_clear;
    test_back_to_back_stall;
    test_zero;
    test_reset_mid;
    test_start_busy;
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
